// File: rtl/imem_fetch_arbiter_if.sv
// Instruction-memory arbiter bus: fetch port, data-side read port and memory port.
// The arbiter connects through the slave modport; the surrounding pipeline/memory use master.
interface imem_fetch_arbiter_if;
    localparam int unsigned XLEN = 32;

    // Fetch stage side
    logic            Fetch_Req;
    logic [XLEN-1:0] Fetch_Addr;
    logic            Flush;
    logic            Fetch_Stall;
    logic [XLEN-1:0] Fetch_Instr;
    logic            Fetch_Valid;

    // Secondary data-side reader
    logic            Data_Req;
    logic [XLEN-1:0] Data_Addr;
    logic            Data_Grant;
    logic [XLEN-1:0] Data_Rdata;
    logic            Data_Valid;

    // Fixed-latency instruction memory
    logic            Mem_Req;
    logic [XLEN-1:0] Mem_Addr;
    logic [XLEN-1:0] Mem_Rdata;

    modport slave (
        input  Fetch_Req, Fetch_Addr, Flush, Data_Req, Data_Addr, Mem_Rdata,
        output Fetch_Stall, Fetch_Instr, Fetch_Valid,
        output Data_Grant, Data_Rdata, Data_Valid,
        output Mem_Req, Mem_Addr
    );

    modport master (
        output Fetch_Req, Fetch_Addr, Flush, Data_Req, Data_Addr, Mem_Rdata,
        input  Fetch_Stall, Fetch_Instr, Fetch_Valid,
        input  Data_Grant, Data_Rdata, Data_Valid,
        input  Mem_Req, Mem_Addr
    );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// Shares a single-ported, fixed-latency instruction memory between IF and a
// data-side reader. One access outstanding at a time; back-to-back issue in the
// response cycle. Fetch responses are discarded after a branch-redirect Flush.
// Optional feature: define IMEM_ARB_STARVE_EN to build the data-side starvation
// guard (data forced to win after STARVE_LIMIT consecutive losses); otherwise
// fetch has strict priority.
module imem_fetch_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    imem_fetch_arbiter_if.slave   bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   lat_cnt_q;
    logic               kill_q;
    logic [XLEN-1:0]    fetch_instr_q;
    logic               fetch_valid_q;
    logic [XLEN-1:0]    data_rdata_q;
    logic               data_valid_q;

    logic               resp_c;
    logic               eligible_c;
    logic               fetch_ok_c;
    logic               starve_hit_c;
    logic               data_win_c;
    logic               fetch_win_c;

    // Starvation guard: count consecutive data losses, force a data win at the limit.
`ifdef IMEM_ARB_STARVE_EN
    logic [3:0] starve_q;

    assign starve_hit_c = (starve_q == 4'(STARVE_LIMIT));

    // Saturating loss counter; cleared when data is granted or stops requesting.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            starve_q <= 4'd0;
        end else if (!bus.Data_Req || data_win_c) begin
            starve_q <= 4'd0;
        end else if (fetch_win_c && (starve_q != 4'hF)) begin
            starve_q <= starve_q + 4'd1;
        end
    end
`else
    logic unused_starve_limit;

    assign starve_hit_c        = 1'b0;
    assign unused_starve_limit = |4'(STARVE_LIMIT);
`endif

    // Arbitration: issue only when idle or in the response cycle, never during reset.
    always_comb begin
        resp_c      = (state_q != IDLE) && (lat_cnt_q == CNT_W'(1));
        eligible_c  = !RESET && ((state_q == IDLE) || resp_c);
        fetch_ok_c  = bus.Fetch_Req && !bus.Flush;
        data_win_c  = eligible_c && bus.Data_Req && (!fetch_ok_c || starve_hit_c);
        fetch_win_c = eligible_c && fetch_ok_c && !data_win_c;
    end

    // Combinational issue strobe/address, grant and fetch stall.
    always_comb begin
        bus.Mem_Req     = fetch_win_c || data_win_c;
        bus.Mem_Addr    = '0;
        if (data_win_c) begin
            bus.Mem_Addr = bus.Data_Addr;
        end else if (fetch_win_c) begin
            bus.Mem_Addr = bus.Fetch_Addr;
        end
        bus.Data_Grant  = data_win_c;
        bus.Fetch_Stall = RESET || (bus.Fetch_Req && !fetch_win_c);
    end

    assign bus.Fetch_Instr = fetch_instr_q;
    assign bus.Fetch_Valid = fetch_valid_q;
    assign bus.Data_Rdata  = data_rdata_q;
    assign bus.Data_Valid  = data_valid_q;

    // Access FSM, latency counter, kill flag and registered response capture.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            lat_cnt_q     <= '0;
            kill_q        <= 1'b0;
            fetch_instr_q <= '0;
            fetch_valid_q <= 1'b0;
            data_rdata_q  <= '0;
            data_valid_q  <= 1'b0;
        end else begin
            fetch_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;

            // A flush during or at the end of an outstanding fetch drops its data.
            if (resp_c) begin
                if (state_q == BUSY_F) begin
                    if (!kill_q && !bus.Flush) begin
                        fetch_instr_q <= bus.Mem_Rdata;
                        fetch_valid_q <= 1'b1;
                    end
                end else begin
                    data_rdata_q <= bus.Mem_Rdata;
                    data_valid_q <= 1'b1;
                end
            end

            if (resp_c) begin
                kill_q <= 1'b0;
            end else if ((state_q == BUSY_F) && bus.Flush) begin
                kill_q <= 1'b1;
            end

            if (fetch_win_c) begin
                state_q   <= BUSY_F;
                lat_cnt_q <= CNT_W'(MEM_LATENCY);
            end else if (data_win_c) begin
                state_q   <= BUSY_D;
                lat_cnt_q <= CNT_W'(MEM_LATENCY);
            end else if (resp_c) begin
                state_q   <= IDLE;
                lat_cnt_q <= '0;
            end else if (state_q != IDLE) begin
                lat_cnt_q <= lat_cnt_q - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter at MEM_LATENCY=2, STARVE_LIMIT=4: vector table for
// per-cycle arbitration, response scoreboard, and hand sequences for corner cases.
module tb_imem_fetch_arbiter;
    localparam int L  = 2;
    localparam int SL = 4;

    logic CLK = 1'b0;
    logic RESET;
    int   cyc   = 0;
    int   nvec  = 0;
    int   nmiss = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    imem_fetch_arbiter_if bus();

    imem_fetch_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Memory contents: one fixed data word, everything else is address ^ 0xFFFF.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0040_0010) return 32'h8C82_0000;
        return a ^ 32'h0000_FFFF;
    endfunction

    // Fixed-latency memory: data for an issue appears exactly L cycles later.
    logic [L-1:0] pv = '0;
    logic [31:0]  pa [L];
    always @(posedge CLK) begin
        for (int k = L - 1; k > 0; k--) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
        pv[0] <= bus.Mem_Req;
        pa[0] <= bus.Mem_Addr;
    end
    assign bus.Mem_Rdata = pv[L-1] ? mem_f(pa[L-1]) : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response scoreboard
    typedef struct {
        logic [31:0] data;
        int          c;
        bit          killed;
    } rsp_t;

    rsp_t        fq[$];
    rsp_t        dq[$];
    rsp_t        e;
    logic [31:0] last_fi;

    always @(negedge CLK) begin
        if (RESET) begin
            fq.delete();
            dq.delete();
            last_fi = '0;
        end else begin
            if (fq.size() > 0 && fq[0].c + L + 1 == cyc) begin
                e = fq.pop_front();
                if (e.killed) begin
                    chk1("fetch_killed_valid", bus.Fetch_Valid, 1'b0);
                    chk("fetch_killed_instr_hold", bus.Fetch_Instr, last_fi);
                end else begin
                    chk1("fetch_valid", bus.Fetch_Valid, 1'b1);
                    chk("fetch_instr", bus.Fetch_Instr, e.data);
                    last_fi = e.data;
                end
            end else begin
                chk1("fetch_spurious_valid", bus.Fetch_Valid, 1'b0);
            end

            if (dq.size() > 0 && dq[0].c + L + 1 == cyc) begin
                e = dq.pop_front();
                chk1("data_valid", bus.Data_Valid, 1'b1);
                chk("data_rdata", bus.Data_Rdata, e.data);
            end else begin
                chk1("data_spurious_valid", bus.Data_Valid, 1'b0);
            end

            if (bus.Flush) begin
                foreach (fq[i]) begin
                    if (cyc > fq[i].c && cyc <= fq[i].c + L) fq[i].killed = 1'b1;
                end
            end

            if (bus.Mem_Req) begin
                if (bus.Data_Grant) begin
                    chk("mem_addr_data", bus.Mem_Addr, bus.Data_Addr);
                    dq.push_back('{mem_f(bus.Data_Addr), cyc, 1'b0});
                end else begin
                    chk("mem_addr_fetch", bus.Mem_Addr, bus.Fetch_Addr);
                    chk1("fetch_req_on_issue", bus.Fetch_Req, 1'b1);
                    fq.push_back('{mem_f(bus.Fetch_Addr), cyc, 1'b0});
                end
            end
        end
    end

    typedef struct packed {
        logic f;
        logic fl;
        logic d;
        logic mem;
        logic stall;
        logic grant;
    } vec_t;

    vec_t tbl [17];

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            bus.Fetch_Req = 1'b0;
            bus.Flush     = 1'b0;
            bus.Data_Req  = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] addr;
        logic        issued;
        int          k;

        // {Fetch_Req, Flush, Data_Req} -> {Mem_Req, Fetch_Stall, Data_Grant}
        tbl[0]  = 6'b100_100;  // idle: fetch issues
        tbl[1]  = 6'b101_010;  // busy: nothing issues
        tbl[2]  = 6'b101_100;  // response: fetch beats data back-to-back
        tbl[3]  = 6'b001_000;
        tbl[4]  = 6'b111_111;  // flush at response: data wins, fetch data dropped
        tbl[5]  = 6'b110_010;  // flush ignored while data busy
        tbl[6]  = 6'b000_000;
        tbl[7]  = 6'b001_101;  // idle: lone data issues
        tbl[8]  = 6'b100_010;
        tbl[9]  = 6'b100_100;  // fetch issues in data response cycle
        tbl[10] = 6'b010_000;  // flush mid-fetch sets kill
        tbl[11] = 6'b100_100;  // killed response; next fetch issues
        tbl[12] = 6'b000_000;
        tbl[13] = 6'b000_000;
        tbl[14] = 6'b110_010;  // flush blocks an idle fetch
        tbl[15] = 6'b000_000;
        tbl[16] = 6'b000_000;

        RESET          = 1'b1;
        bus.Fetch_Req  = 1'b0;
        bus.Fetch_Addr = '0;
        bus.Flush      = 1'b0;
        bus.Data_Req   = 1'b0;
        bus.Data_Addr  = '0;

        // Reset values with both requesters active
        repeat (2) @(posedge CLK);
        #1;
        bus.Fetch_Req  = 1'b1;
        bus.Data_Req   = 1'b1;
        bus.Fetch_Addr = 32'h0000_1234;
        bus.Data_Addr  = 32'h0000_5678;
        @(negedge CLK);
        chk1("rst_fetch_stall", bus.Fetch_Stall, 1'b1);
        chk1("rst_mem_req", bus.Mem_Req, 1'b0);
        chk("rst_mem_addr", bus.Mem_Addr, 32'h0);
        chk1("rst_data_grant", bus.Data_Grant, 1'b0);
        chk1("rst_fetch_valid", bus.Fetch_Valid, 1'b0);
        chk("rst_fetch_instr", bus.Fetch_Instr, 32'h0);
        chk1("rst_data_valid", bus.Data_Valid, 1'b0);
        chk("rst_data_rdata", bus.Data_Rdata, 32'h0);
        @(posedge CLK);
        #1;
        RESET         = 1'b0;
        bus.Fetch_Req = 1'b0;
        bus.Data_Req  = 1'b0;
        idle(2);

        // Table-driven arbitration vectors
        for (int i = 0; i < 17; i++) begin
            @(posedge CLK);
            #1;
            bus.Fetch_Req  = tbl[i].f;
            bus.Flush      = tbl[i].fl;
            bus.Data_Req   = tbl[i].d;
            bus.Fetch_Addr = 32'h0000_1000 + (32'(i) << 2);
            bus.Data_Addr  = 32'h0000_2000 + (32'(i) << 2);
            @(negedge CLK);
            chk1("tbl_mem_req", bus.Mem_Req, tbl[i].mem);
            chk1("tbl_fetch_stall", bus.Fetch_Stall, tbl[i].stall);
            chk1("tbl_data_grant", bus.Data_Grant, tbl[i].grant);
        end
        idle(4);

        // Continuous fetch stream from the boot vector: one issue every L cycles
        addr   = 32'hBFC0_0000;
        issued = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            if (issued) addr = addr + 32'd4;
            bus.Fetch_Req  = 1'b1;
            bus.Fetch_Addr = addr;
            @(negedge CLK);
            chk1("tput_mem_req", bus.Mem_Req, (i % L) == 0);
            issued = bus.Mem_Req;
        end
        idle(4);

        // Both requesting continuously: grant pattern depends on the starvation guard
        k = 0;
        for (int i = 0; i < 60 && k < 15; i++) begin
            @(posedge CLK);
            #1;
            bus.Fetch_Req  = 1'b1;
            bus.Data_Req   = 1'b1;
            bus.Fetch_Addr = 32'h0000_7000 + (32'(i) << 2);
            bus.Data_Addr  = 32'h0000_8000 + (32'(i) << 2);
            @(negedge CLK);
            if (bus.Mem_Req) begin
`ifdef IMEM_ARB_STARVE_EN
                chk1("starve_grant_seq", bus.Data_Grant, (k % (SL + 1)) == SL);
`else
                chk1("starve_grant_seq", bus.Data_Grant, 1'b0);
`endif
                k++;
            end
        end
        chk("starve_issue_count", 32'(k), 32'd15);
        idle(4);

        // Lone data read of a known word
        @(posedge CLK);
        #1;
        bus.Data_Req  = 1'b1;
        bus.Data_Addr = 32'h0040_0010;
        @(negedge CLK);
        chk1("dat_grant", bus.Data_Grant, 1'b1);
        chk1("dat_fetch_stall", bus.Fetch_Stall, 1'b0);
        chk("dat_mem_addr", bus.Mem_Addr, 32'h0040_0010);
        @(posedge CLK);
        #1;
        bus.Data_Req = 1'b0;
        repeat (L) @(posedge CLK);
        @(negedge CLK);
        chk1("dat_valid_at_lat", bus.Data_Valid, 1'b1);
        chk("dat_rdata_word", bus.Data_Rdata, 32'h8C82_0000);
        idle(4);

        // Data request withdrawn before it could be granted
        @(posedge CLK);
        #1;
        bus.Fetch_Req  = 1'b1;
        bus.Fetch_Addr = 32'h0000_3000;
        @(posedge CLK);
        #1;
        bus.Fetch_Req = 1'b0;
        bus.Data_Req  = 1'b1;
        bus.Data_Addr = 32'h0000_3100;
        @(negedge CLK);
        chk1("drop_no_grant_busy", bus.Data_Grant, 1'b0);
        @(posedge CLK);
        #1;
        bus.Data_Req = 1'b0;
        @(negedge CLK);
        chk1("drop_no_issue", bus.Mem_Req, 1'b0);
        idle(4);

        // Reset asserted while a data read is outstanding
        @(posedge CLK);
        #1;
        bus.Data_Req  = 1'b1;
        bus.Data_Addr = 32'h0000_5000;
        @(negedge CLK);
        chk1("rmid_grant", bus.Data_Grant, 1'b1);
        @(posedge CLK);
        #1;
        bus.Data_Req  = 1'b0;
        bus.Fetch_Req = 1'b1;
        #2;
        RESET = 1'b1;
        #1;
        chk1("rmid_mem_req", bus.Mem_Req, 1'b0);
        chk1("rmid_fetch_stall", bus.Fetch_Stall, 1'b1);
        chk1("rmid_data_grant", bus.Data_Grant, 1'b0);
        chk1("rmid_data_valid", bus.Data_Valid, 1'b0);
        chk("rmid_data_rdata", bus.Data_Rdata, 32'h0);
        chk("rmid_fetch_instr", bus.Fetch_Instr, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RESET          = 1'b0;
        bus.Fetch_Req  = 1'b1;
        bus.Fetch_Addr = 32'h0000_6000;
        @(negedge CLK);
        chk1("rmid_first_issue", bus.Mem_Req, 1'b1);
        chk1("rmid_first_nostall", bus.Fetch_Stall, 1'b0);
        for (int i = 0; i < L + 3; i++) begin
            @(posedge CLK);
            #1;
            bus.Fetch_Req = 1'b0;
            @(negedge CLK);
            chk1("rmid_no_data_valid", bus.Data_Valid, 1'b0);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end
endmodule

// File: doc/imem_fetch_arbiter.md
# imem_fetch_arbiter

Shares the single-ported instruction memory between the fetch stage and a secondary data-side reader (loads from the text segment or a program loader). The block issues one memory access at a time against a fixed-latency memory and returns registered read data to the winner. It drives the fetch stage's stall input and honours branch-redirect flushes by discarding stale fetch responses. It sits between IF and the instruction memory, in place of IF's direct address/data connection.

## Interface
- MEM_LATENCY, 1: cycles from issue to `Mem_Rdata` valid; legal range 1..7.
- STARVE_LIMIT, 4: consecutive data-side losses before data is forced to win; legal range 1..15.

- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- Fetch_Req  input  1  IF requests the instruction at `Fetch_Addr`.
- Fetch_Addr  input  32  fetch address.
- Flush  input  1  branch redirect: the outstanding or current fetch is stale.
- Fetch_Stall  output  1  freezes IF; driven combinationally.
- Fetch_Instr  output  32  registered fetch data.
- Fetch_Valid  output  1  one-cycle pulse qualifying `Fetch_Instr`.
- Data_Req  input  1  data-side read request; held until granted.
- Data_Addr  input  32  data-side address.
- Data_Grant  output  1  combinational; the data request is issued this cycle.
- Data_Rdata  output  32  registered data-side read data.
- Data_Valid  output  1  one-cycle pulse qualifying `Data_Rdata`.
- Mem_Req  output  1  combinational issue strobe to memory.
- Mem_Addr  output  32  combinational issue address to memory.
- Mem_Rdata  input  32  memory read data, valid exactly MEM_LATENCY cycles after issue.

## Operation
- FSM states:
  - IDLE: no access outstanding.
  - BUSY_F: fetch outstanding.
  - BUSY_D: data read outstanding.
- A 3-bit latency counter is loaded with MEM_LATENCY on issue and decrements each cycle.
- Response cycle: BUSY_* with counter == 1, or any cycle in which the counter reaches the response.
- Issue is eligible in IDLE or in the response cycle, so back-to-back issue is allowed.
- Arbitration in an eligible cycle:
  - Only one requester active: that requester wins.
  - Both active: fetch wins, unless the starve counter equals STARVE_LIMIT; then data wins.
  - A fetch with `Flush` high in the same cycle is not issued; data may win instead.
- Starve counter (4-bit, saturating):
  - Increments when data loses to fetch.
  - Clears when data is granted or `Data_Req` is low.
- Issue cycle: `Mem_Req`=1 and `Mem_Addr`=winner's address. Otherwise `Mem_Req`=0 and `Mem_Addr`=0.
- Response capture, at the edge ending the response cycle:
  - `Mem_Rdata` is written to `Fetch_Instr` or `Data_Rdata`.
  - The matching Valid output is set for exactly one cycle.
- `Fetch_Stall` = `Fetch_Req` AND NOT (fetch issued this cycle). It is also 1 while RESET is high.
- Flush while BUSY_F sets a kill flag. At response, `Fetch_Instr` is not updated, `Fetch_Valid` stays 0, and the flag clears. Flush has no effect on BUSY_D.

## Timing
- Reset values:
  - `Fetch_Instr`=0, `Fetch_Valid`=0, `Data_Rdata`=0, `Data_Valid`=0.
  - `Mem_Req`=0, `Mem_Addr`=0, `Data_Grant`=0, `Fetch_Stall`=1.
  - FSM=IDLE; counters and kill flag = 0.
- Latency: issue at cycle t gives Valid high in cycle t+MEM_LATENCY+1.
- Peak throughput is one access per MEM_LATENCY cycles. With MEM_LATENCY=1 this is one per cycle.
- Reset asserted mid-access: the outstanding response is dropped, no Valid is pulsed after release, and the first issue is possible in the first cycle after RESET falls.
- Flush and response in the same cycle: the response is discarded.
- `Data_Req` dropped before grant is legal; no access results.

## Configuration
- `IMEM_ARB_STARVE_EN` defined: the starvation guard operates as described.
- `IMEM_ARB_STARVE_EN` undefined:
  - Strict fetch priority: data wins only when `Fetch_Req` is low or Flush blocks the fetch.
  - The starve counter is not built.
  - STARVE_LIMIT is ignored.

## Test plan
- Reset release, MEM_LATENCY=1, `Fetch_Req`=1 with `Fetch_Addr`=0xBFC00000 then +4 each grant, memory returns address^0xFFFF -> `Mem_Req` high every cycle; `Fetch_Valid` continuous from cycle 2; `Fetch_Instr`=0xBFC0FFFF then 0xBFC0FFFB.
- MEM_LATENCY=3, single fetch at cycle 0 -> `Fetch_Stall` low at 0; `Mem_Req` low on cycles 1–2; `Fetch_Valid` pulse at cycle 4.
- Both requesting continuously, STARVE_LIMIT=4, `IMEM_ARB_STARVE_EN` defined -> grant sequence F,F,F,F,D repeating; `Data_Grant` on every 5th issue. Without the macro -> data never granted.
- Fetch issued, `Flush` asserted one cycle later, MEM_LATENCY=2 -> no `Fetch_Valid`; `Fetch_Instr` holds its prior value; the next fetch issues in the response cycle.
- RESET asserted during BUSY_D with MEM_LATENCY=4 -> all outputs return to their reset values immediately; no `Data_Valid` ever appears for that access.
- `Data_Req` alone at 0x00400010, memory returns 0x8C820000 -> `Data_Grant` in the same cycle; `Data_Rdata`=0x8C820000 with `Data_Valid` MEM_LATENCY+1 cycles later; `Fetch_Stall`=0 while `Fetch_Req`=0.
